bcd_tick_timer: RTL and testbench

Countdown timer in MM:SS BCD that consumes the divided toggle output of the clock divider as its time base. It runs on the fast system clock and treats the divided signal as data, never as a clock. A rising edge on the divided input is one tick, so a 1 Hz tick comes from a 100 MHz clock with a divide constant of 50,000,000. The block feeds the display/annunciator logic with BCD digits, a running flag and an expiry pulse.

---
 rtl/bcd_tick_timer_pkg.sv | 27 ++
 rtl/bcd_digit_down.sv | 23 ++
 rtl/bcd_tick_timer.sv | 131 +++++++++++++
 tb/tb_bcd_tick_timer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_tick_timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: state encodings,
// BCD digit limits and the preset validity check.
package bcd_tick_timer_pkg;

  localparam int STATE_W = 2;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Both operands are valid BCD when the digit tests pass, so a plain binary
  // compare orders them the same way as their decimal values.
  function automatic logic preset_valid(input logic [7:0] mm,
                                        input logic [7:0] ss,
                                        input logic [7:0] max_mm);
    return (mm[7:4] <= DIGIT_MAX) && (mm[3:0] <= DIGIT_MAX) &&
           (ss[7:4] <= SEC_TENS_MAX) && (ss[3:0] <= DIGIT_MAX) &&
           (mm <= max_mm);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counting borrow chain: decrements when borrow_in
// is set, wrapping from 0 to the programmed wrap value with a borrow out.
module bcd_digit_down (
  input  logic [3:0] digit,
  input  logic [3:0] wrap,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  logic is_zero;

  assign is_zero    = (digit == 4'd0);
  assign borrow_out = borrow_in & is_zero;

  always_comb begin
    next_digit = digit;
    if (borrow_in) begin
      next_digit = is_zero ? wrap : (digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_tick_timer.sv
// MM:SS BCD countdown timer driven by rising edges of a divided tick signal.
// Define BCD_TICK_TIMER_SYNC_EN to pass tick_in through a 2-flop synchronizer.
module bcd_tick_timer
  import bcd_tick_timer_pkg::*;
#(
  parameter int unsigned SEC_PRESCALE = 1,
  parameter logic [7:0]  MAX_MIN_BCD  = 8'h59
) (
  input  logic               bcd_tick_timer_clk,
  input  logic               bcd_tick_timer_rst_n,
  input  logic               bcd_tick_timer_tick_in,
  input  logic               bcd_tick_timer_load,
  input  logic [7:0]         bcd_tick_timer_load_min,
  input  logic [7:0]         bcd_tick_timer_load_sec,
  input  logic               bcd_tick_timer_start,
  input  logic               bcd_tick_timer_stop,
  output logic [7:0]         bcd_tick_timer_min,
  output logic [7:0]         bcd_tick_timer_sec,
  output logic               bcd_tick_timer_running,
  output logic               bcd_tick_timer_done,
  output logic               bcd_tick_timer_load_err,
  output logic [STATE_W-1:0] bcd_tick_timer_state
);

  localparam logic [7:0] PRESC_LAST = 8'(SEC_PRESCALE - 1);

  state_t     state;
  logic [7:0] min_q, sec_q, presc_q;
  logic       tick_src, tick_q, tick;
  logic       running_q, done_q, load_err_q;

`ifdef BCD_TICK_TIMER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge bcd_tick_timer_clk or negedge bcd_tick_timer_rst_n) begin
    if (!bcd_tick_timer_rst_n) sync_q <= 2'b00;
    else                       sync_q <= {sync_q[0], bcd_tick_timer_tick_in};
  end
  assign tick_src = sync_q[1];
`else
  assign tick_src = bcd_tick_timer_tick_in;
`endif

  always_ff @(posedge bcd_tick_timer_clk or negedge bcd_tick_timer_rst_n) begin
    if (!bcd_tick_timer_rst_n) tick_q <= 1'b0;
    else                       tick_q <= tick_src;
  end
  assign tick = tick_src & ~tick_q;

  // Borrow chain: seconds units always request a borrow; it is applied only on dec.
  logic [3:0] su_n, st_n, mu_n, mt_n;
  logic       su_b, st_b, mu_b, mt_b;

  bcd_digit_down u_sec_units (.digit(sec_q[3:0]), .wrap(DIGIT_MAX),    .borrow_in(1'b1),
                              .next_digit(su_n), .borrow_out(su_b));
  bcd_digit_down u_sec_tens  (.digit(sec_q[7:4]), .wrap(SEC_TENS_MAX), .borrow_in(su_b),
                              .next_digit(st_n), .borrow_out(st_b));
  bcd_digit_down u_min_units (.digit(min_q[3:0]), .wrap(DIGIT_MAX),    .borrow_in(st_b),
                              .next_digit(mu_n), .borrow_out(mu_b));
  bcd_digit_down u_min_tens  (.digit(min_q[7:4]), .wrap(DIGIT_MAX),    .borrow_in(mu_b),
                              .next_digit(mt_n), .borrow_out(mt_b));

  logic at_last, dec, next_zero, count_zero, load_ok;

  assign at_last    = (presc_q == PRESC_LAST);
  // A borrow out of the top digit would mean counting below 00:00; never apply it.
  assign dec        = (state == ST_RUN) && tick && at_last && !mt_b;
  assign next_zero  = ({mt_n, mu_n, st_n, su_n} == 16'h0000);
  assign count_zero = ({min_q, sec_q} == 16'h0000);
  assign load_ok    = preset_valid(bcd_tick_timer_load_min, bcd_tick_timer_load_sec, MAX_MIN_BCD);

  always_ff @(posedge bcd_tick_timer_clk or negedge bcd_tick_timer_rst_n) begin
    if (!bcd_tick_timer_rst_n) begin
      state      <= ST_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      presc_q    <= 8'h00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (tick) presc_q <= at_last ? 8'h00 : (presc_q + 8'd1);
          if (dec) begin
            min_q <= {mt_n, mu_n};
            sec_q <= {st_n, su_n};
          end
          if (dec && next_zero) begin
            state     <= ST_EXPIRED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bcd_tick_timer_stop) begin
            state     <= ST_PAUSE;
            running_q <= 1'b0;
          end
        end
        default: begin
          // IDLE, PAUSE and EXPIRED all accept a load; only IDLE/PAUSE accept start.
          if (bcd_tick_timer_load) begin
            if (load_ok) begin
              min_q   <= bcd_tick_timer_load_min;
              sec_q   <= bcd_tick_timer_load_sec;
              presc_q <= 8'h00;
              state   <= ST_IDLE;
            end else begin
              load_err_q <= 1'b1;
            end
          end else if ((state != ST_EXPIRED) && bcd_tick_timer_start && !bcd_tick_timer_stop) begin
            if (count_zero) begin
              state  <= ST_EXPIRED;
              done_q <= 1'b1;
            end else begin
              state     <= ST_RUN;
              running_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bcd_tick_timer_min      = min_q;
  assign bcd_tick_timer_sec      = sec_q;
  assign bcd_tick_timer_running  = running_q;
  assign bcd_tick_timer_done     = done_q;
  assign bcd_tick_timer_load_err = load_err_q;
  assign bcd_tick_timer_state    = state;

endmodule

// File: tb/tb_bcd_tick_timer.sv
// Directed bench for bcd_tick_timer: one instance with prescale 1, one with
// prescale 4; expected counts go through a scoreboard queue.
module tb_bcd_tick_timer;

`ifdef BCD_TICK_TIMER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk, rst_n, tick_in;
  logic [7:0] load_min, load_sec;
  logic       load1, start1, stop1, load2, start2, stop2;
  logic [7:0] min1, sec1, min2, sec2;
  logic       running1, done1, load_err1, running2, done2, load_err2;
  logic [1:0] state1, state2;

  logic [15:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  bcd_tick_timer #(.SEC_PRESCALE(1), .MAX_MIN_BCD(8'h59)) u_dut1 (
    .bcd_tick_timer_clk(clk), .bcd_tick_timer_rst_n(rst_n),
    .bcd_tick_timer_tick_in(tick_in), .bcd_tick_timer_load(load1),
    .bcd_tick_timer_load_min(load_min), .bcd_tick_timer_load_sec(load_sec),
    .bcd_tick_timer_start(start1), .bcd_tick_timer_stop(stop1),
    .bcd_tick_timer_min(min1), .bcd_tick_timer_sec(sec1),
    .bcd_tick_timer_running(running1), .bcd_tick_timer_done(done1),
    .bcd_tick_timer_load_err(load_err1), .bcd_tick_timer_state(state1)
  );

  bcd_tick_timer #(.SEC_PRESCALE(4), .MAX_MIN_BCD(8'h59)) u_dut2 (
    .bcd_tick_timer_clk(clk), .bcd_tick_timer_rst_n(rst_n),
    .bcd_tick_timer_tick_in(tick_in), .bcd_tick_timer_load(load2),
    .bcd_tick_timer_load_min(load_min), .bcd_tick_timer_load_sec(load_sec),
    .bcd_tick_timer_start(start2), .bcd_tick_timer_stop(stop2),
    .bcd_tick_timer_min(min2), .bcd_tick_timer_sec(sec2),
    .bcd_tick_timer_running(running2), .bcd_tick_timer_done(done2),
    .bcd_tick_timer_load_err(load_err2), .bcd_tick_timer_state(state2)
  );

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      chk_cnt++;
      fail_cnt++;
      $error("FAIL %s: got %h expected <empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // Driver tasks
  task automatic do_load1(input logic [7:0] mm, input logic [7:0] ss);
    load_min = mm; load_sec = ss; load1 = 1'b1;
    cyc();
    load1 = 1'b0;
  endtask

  task automatic do_load2(input logic [7:0] mm, input logic [7:0] ss);
    load_min = mm; load_sec = ss; load2 = 1'b1;
    cyc();
    load2 = 1'b0;
  endtask

  task automatic do_start1(); start1 = 1'b1; cyc(); start1 = 1'b0; endtask
  task automatic do_stop1();  stop1  = 1'b1; cyc(); stop1  = 1'b0; endtask
  task automatic do_start2(); start2 = 1'b1; cyc(); start2 = 1'b0; endtask
  task automatic do_stop2();  stop2  = 1'b1; cyc(); stop2  = 1'b0; endtask

  // Rising edge: returns on the cycle the count first reflects it.
  task automatic tick_rise();
    tick_in = 1'b1;
    repeat (LAT) cyc();
  endtask

  task automatic tick_fall();
    repeat (4 - LAT) cyc();
    tick_in = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic full_tick2(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tick_rise();
    check_count(tag, {min2, sec2});
    tick_fall();
  endtask

  initial begin
    rst_n = 1'b0; tick_in = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    load1 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
    load2 = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    repeat (3) cyc();
    chk("rst_count", {min1, sec1}, 16'h0000);
    chk("rst_state", 16'(state1), 16'd0);
    chk("rst_flags", {13'd0, running1, done1, load_err1}, 16'd0);
    chk("rst_count2", {min2, sec2}, 16'h0000);
    rst_n = 1'b1;
    cyc();

    // 01:00 -> 00:59 on first edge
    do_load1(8'h01, 8'h00);
    chk("load_0100", {min1, sec1}, 16'h0100);
    chk("load_idle", 16'(state1), 16'd0);
    do_start1();
    chk("start_run", {14'd0, state1}, 16'd1);
    chk("start_running", 16'(running1), 16'd1);
    exp_q.push_back(16'h0059);
    tick_rise();
    check_count("first_tick", {min1, sec1});
    tick_fall();

    // Load in RUN is ignored without load_err
    do_load1(8'h00, 8'h02);
    chk("run_load_cnt", {min1, sec1}, 16'h0059);
    chk("run_load_err", 16'(load_err1), 16'd0);
    chk("run_load_state", 16'(state1), 16'd1);
    do_stop1();
    chk("stop_pause", 16'(state1), 16'd2);
    chk("stop_running", 16'(running1), 16'd0);

    // 00:02 -> expiry
    do_load1(8'h00, 8'h02);
    chk("load_0002", {min1, sec1}, 16'h0002);
    do_start1();
    exp_q.push_back(16'h0001);
    tick_rise();
    check_count("exp_tick1", {min1, sec1});
    tick_fall();
    exp_q.push_back(16'h0000);
    tick_rise();
    check_count("exp_tick2", {min1, sec1});
    chk("exp_done", 16'(done1), 16'd1);
    chk("exp_state", 16'(state1), 16'd3);
    chk("exp_running", 16'(running1), 16'd0);
    cyc();
    chk("exp_done_once", 16'(done1), 16'd0);
    tick_fall();
    do_start1();
    chk("exp_start_ign", 16'(state1), 16'd3);

    // Invalid presets
    do_load1(8'h7A, 8'h30);
    chk("bad_min_err", 16'(load_err1), 16'd1);
    chk("bad_min_cnt", {min1, sec1}, 16'h0000);
    chk("bad_min_state", 16'(state1), 16'd3);
    cyc();
    chk("bad_err_pulse", 16'(load_err1), 16'd0);
    do_load1(8'h00, 8'h60);
    chk("bad_sec_err", 16'(load_err1), 16'd1);
    do_load1(8'h60, 8'h00);
    chk("over_max_err", 16'(load_err1), 16'd1);
    do_load1(8'h59, 8'h59);
    chk("max_ok_err", 16'(load_err1), 16'd0);
    chk("max_ok_cnt", {min1, sec1}, 16'h5959);
    chk("max_ok_state", 16'(state1), 16'd0);

    // Stop on the same cycle as a decrement
    do_load1(8'h10, 8'h00);
    do_start1();
    exp_q.push_back(16'h0959);
    tick_in = 1'b1;
    repeat (LAT - 1) cyc();
    stop1 = 1'b1;
    cyc();
    stop1 = 1'b0;
    check_count("stop_tick_cnt", {min1, sec1});
    chk("stop_tick_state", 16'(state1), 16'd2);
    chk("stop_tick_run", 16'(running1), 16'd0);
    tick_fall();
    exp_q.push_back(16'h0959);
    tick_rise();
    check_count("paused_tick", {min1, sec1});
    tick_fall();
    start1 = 1'b1; stop1 = 1'b1;
    cyc();
    start1 = 1'b0; stop1 = 1'b0;
    chk("stop_wins", 16'(state1), 16'd2);

    // Start at 00:00 expires immediately
    do_load1(8'h00, 8'h00);
    chk("zero_idle", 16'(state1), 16'd0);
    do_start1();
    chk("zero_start_st", 16'(state1), 16'd3);
    chk("zero_start_done", 16'(done1), 16'd1);

    // Prescale 4 instance
    do_load2(8'h00, 8'h05);
    do_start2();
    chk("p4_run", 16'(state2), 16'd1);
    full_tick2("p4_e1", 16'h0005);
    full_tick2("p4_e2", 16'h0005);
    full_tick2("p4_e3", 16'h0005);
    full_tick2("p4_e4", 16'h0004);
    full_tick2("p4_e5", 16'h0004);
    full_tick2("p4_e6", 16'h0004);
    do_stop2();
    chk("p4_pause", 16'(state2), 16'd2);
    full_tick2("p4_hold1", 16'h0004);
    full_tick2("p4_hold2", 16'h0004);
    do_start2();
    full_tick2("p4_e7", 16'h0004);
    full_tick2("p4_e8", 16'h0003);

    // Asynchronous reset mid-run
    do_load1(8'h03, 8'h17);
    do_start1();
    chk("pre_rst_run", 16'(state1), 16'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {min1, sec1}, 16'h0000);
    chk("arst_state", 16'(state1), 16'd0);
    chk("arst_flags", {14'd0, running1, done1}, 16'd0);
    cyc();
    cyc();
    chk("arst_no_done", 16'(done1), 16'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_state", 16'(state1), 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
